// File: rtl/spi_master_module_if.sv
// spi_master_module_if
//   Bundles the request/response handshake and the four SPI bus wires of
//   spi_master_module.
//   Request : i_start, i_rw, i_addr, i_wdata
//   Response: o_busy, o_done, o_rdata
//   SPI bus : o_SCLK, o_SS, o_MOSI (master drive), i_MISO (slave return)
//   modport master : the SPI master itself
//   modport slave  : whatever issues requests and models the SPI slave
interface spi_master_module_if #(
  parameter int SPI_ADDR_LEN = 8,
  parameter int SPI_WORD_LEN = 16
);
  logic                    i_start;
  logic                    i_rw;
  logic [SPI_ADDR_LEN-1:0] i_addr;
  logic [SPI_WORD_LEN-1:0] i_wdata;
  logic                    o_busy;
  logic                    o_done;
  logic [SPI_WORD_LEN-1:0] o_rdata;
  logic                    o_SCLK;
  logic                    o_SS;
  logic                    o_MOSI;
  logic                    i_MISO;

  modport master (
    input  i_start, i_rw, i_addr, i_wdata, i_MISO,
    output o_busy, o_done, o_rdata, o_SCLK, o_SS, o_MOSI
  );

  modport slave (
    output i_start, i_rw, i_addr, i_wdata, i_MISO,
    input  o_busy, o_done, o_rdata, o_SCLK, o_SS, o_MOSI
  );
endinterface

// File: rtl/spi_master_module.sv
// spi_master_module
//   SPI mode-0 master issuing one register access per frame:
//   rw bit, address, then either write data or (read) turnaround + read data.
//   All fields MSB first. SCLK half-period is CLK_DIV clocks.
//   Ports:
//     i_master_clock : sole clock, rising edge
//     i_rst          : synchronous active-high reset
//     bus            : spi_master_module_if.master (handshake + SPI wires)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | SS high, waiting for i_start
//   SETUP | SS low, first MOSI bit driven, SCLK low for one half-period
//   SHIFT | SCLK toggling; MISO sampled on rise, MOSI advanced on fall
//   HOLD  | last falling edge done, SS still low for one half-period
//   GAP   | SS high for one half-period before the next frame may start
module spi_master_module #(
  parameter int SPI_ADDR_LEN = 8,
  parameter int SPI_WORD_LEN = 16,
  parameter int SPI_WAIT_LEN = 2,
  parameter int CLK_DIV      = 4
) (
  input  logic                  i_master_clock,
  input  logic                  i_rst,
  spi_master_module_if.master   bus
);

  localparam int FRAME_W    = 1 + SPI_ADDR_LEN + SPI_WORD_LEN;
  localparam int FRAME_R    = 1 + SPI_ADDR_LEN + SPI_WAIT_LEN + SPI_WORD_LEN;
  localparam int DATA_START = 1 + SPI_ADDR_LEN + SPI_WAIT_LEN;
  localparam int TMR_W      = $clog2(CLK_DIV);
  localparam int CNT_W      = $clog2(FRAME_R + 1);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_R-1:0]      tx_q, tx_d;
  logic [SPI_WORD_LEN-1:0] rx_q, rx_d;
  logic                    rw_q, rw_d;
  logic                    sclk_q, sclk_d;
  logic                    ss_q, ss_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [SPI_WORD_LEN-1:0] rdata_q, rdata_d;

  logic tmr_tc;
  logic last_fall;

  assign tmr_tc    = (tmr_q == '0);
  assign last_fall = (bit_cnt_q == (rw_q ? CNT_W'(FRAME_R - 1) : CNT_W'(FRAME_W - 1)));

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    sclk_d    = sclk_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;

    // Half-period down-counter free-runs in every frame state.
    if (state_q != S_IDLE) begin
      tmr_d = tmr_tc ? TMR_RELOAD : tmr_q - TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          // Frame image left-aligned in the read-sized register; unused
          // trailing bits and the whole read tail stay 0 so MOSI idles low.
          tx_d = '0;
          tx_d[FRAME_R-1] = bus.i_rw;
          tx_d[FRAME_R-2 -: SPI_ADDR_LEN] = bus.i_addr;
          if (!bus.i_rw) begin
            tx_d[FRAME_R-2-SPI_ADDR_LEN -: SPI_WORD_LEN] = bus.i_wdata;
          end
          rw_d      = bus.i_rw;
          mosi_d    = bus.i_rw;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
          tmr_d     = TMR_RELOAD;
          bit_cnt_d = '0;
          rx_d      = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_tc) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tmr_tc) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (rw_q && (bit_cnt_q >= CNT_W'(DATA_START))) begin
              rx_d = {rx_q[SPI_WORD_LEN-2:0], bus.i_MISO};
            end
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = tx_q << 1;
            if (last_fall) begin
              mosi_d  = 1'b0;
              state_d = S_HOLD;
            end else begin
              mosi_d  = tx_q[FRAME_R-2];
            end
          end
        end
      end
      S_HOLD: begin
        if (tmr_tc) begin
          ss_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_tc) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q) rdata_d = rx_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      sclk_q    <= sclk_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.o_SCLK  = sclk_q;
  assign bus.o_SS    = ss_q;
  assign bus.o_MOSI  = mosi_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_module.sv
// Bench for spi_master_module: two instances (CLK_DIV=4 and CLK_DIV=2) on
// one clock, each with a bus monitor that acts as the SPI slave.
module tb_spi_master_module;
  logic clk;
  logic rst0, rst1;
  int   n_assert = 0;
  int   n_fail   = 0;

  spi_master_module_if #(.SPI_ADDR_LEN(8), .SPI_WORD_LEN(16)) b0 ();
  spi_master_module_if #(.SPI_ADDR_LEN(8), .SPI_WORD_LEN(16)) b1 ();

  spi_master_module #(.SPI_ADDR_LEN(8), .SPI_WORD_LEN(16), .SPI_WAIT_LEN(2), .CLK_DIV(4))
    u_dut0 (.i_master_clock(clk), .i_rst(rst0), .bus(b0.master));
  spi_master_module #(.SPI_ADDR_LEN(8), .SPI_WORD_LEN(16), .SPI_WAIT_LEN(2), .CLK_DIV(2))
    u_dut1 (.i_master_clock(clk), .i_rst(rst1), .bus(b1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave returns read word bits during bit slots 11..26 (1 rw + 8 addr + 2 wait).
  function automatic logic slave_bit(input logic [15:0] w, input int idx);
    if (idx >= 11 && idx < 27) return w[26-idx];
    return 1'b0;
  endfunction

  logic [15:0] sword0 = '0, sword1 = '0;
  logic [15:0] exp_rd0 = '0, exp_rd1 = '0;

  // ---------------- bus monitor / slave model, instance 0 ----------------
  int rise0 = 0, done_cnt0 = 0, edge_viol0 = 0, dw_viol0 = 0, hi_run0 = 0, last_gap0 = 0;
  logic [31:0] cap0 = '0;
  bit p_ss0 = 1'b1, p_sclk0 = 1'b0, p_done0 = 1'b0;
  always @(negedge clk) begin
    if (p_ss0 && b0.o_SS === 1'b0) begin last_gap0 = hi_run0; rise0 = 0; cap0 = '0; end
    if ((b0.o_SS === 1'b1) != p_ss0 && b0.o_SCLK !== 1'b0) edge_viol0++;
    hi_run0 = (b0.o_SS === 1'b1) ? hi_run0 + 1 : 0;
    if (!p_sclk0 && b0.o_SCLK === 1'b1 && b0.o_SS === 1'b0) begin
      cap0 = {cap0[30:0], b0.o_MOSI}; rise0++;
    end
    if (b0.o_SS !== 1'b0) b0.i_MISO = 1'b0;
    else if ((p_sclk0 && b0.o_SCLK === 1'b0) || p_ss0) b0.i_MISO = slave_bit(sword0, rise0);
    if (b0.o_done === 1'b1) begin done_cnt0++; if (p_done0) dw_viol0++; end
    p_ss0 = (b0.o_SS === 1'b1); p_sclk0 = (b0.o_SCLK === 1'b1); p_done0 = (b0.o_done === 1'b1);
  end

  // ---------------- bus monitor / slave model, instance 1 ----------------
  int rise1 = 0, done_cnt1 = 0, edge_viol1 = 0, dw_viol1 = 0;
  logic [31:0] cap1 = '0;
  bit p_ss1 = 1'b1, p_sclk1 = 1'b0, p_done1 = 1'b0;
  always @(negedge clk) begin
    if (p_ss1 && b1.o_SS === 1'b0) begin rise1 = 0; cap1 = '0; end
    if ((b1.o_SS === 1'b1) != p_ss1 && b1.o_SCLK !== 1'b0) edge_viol1++;
    if (!p_sclk1 && b1.o_SCLK === 1'b1 && b1.o_SS === 1'b0) begin
      cap1 = {cap1[30:0], b1.o_MOSI}; rise1++;
    end
    if (b1.o_SS !== 1'b0) b1.i_MISO = 1'b0;
    else if ((p_sclk1 && b1.o_SCLK === 1'b0) || p_ss1) b1.i_MISO = slave_bit(sword1, rise1);
    if (b1.o_done === 1'b1) begin done_cnt1++; if (p_done1) dw_viol1++; end
    p_ss1 = (b1.o_SS === 1'b1); p_sclk1 = (b1.o_SCLK === 1'b1); p_done1 = (b1.o_done === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit st, input bit rw,
                       input logic [7:0] a, input logic [15:0] d);
    if (sel == 0) begin b0.i_start = st; b0.i_rw = rw; b0.i_addr = a; b0.i_wdata = d; end
    else          begin b1.i_start = st; b1.i_rw = rw; b1.i_addr = a; b1.i_wdata = d; end
  endtask

  // Expected bit stream as a number: write = {0,addr,data}, read = {1,addr,18'b0}.
  function automatic logic [31:0] frame_bits(input bit rw, input logic [7:0] a, input logic [15:0] d);
    if (rw) return (32'd1 << 26) | (32'(a) << 18);
    return (32'(a) << 16) | 32'(d);
  endfunction

  task automatic run_frame(input int sel, input bit rw, input logic [7:0] a,
                           input logic [15:0] d, input logic [15:0] sw, input bit poke);
    int n, cd, busy, dc0;
    n  = rw ? 27 : 25;
    cd = (sel == 0) ? 4 : 2;
    if (sel == 0) sword0 = sw; else sword1 = sw;
    @(negedge clk);
    dc0 = (sel == 0) ? done_cnt0 : done_cnt1;
    drive(sel, 1'b1, rw, a, d);
    @(negedge clk);
    drive(sel, 1'b0, rw, a, d);
    busy = 0;
    while (((sel == 0) ? b0.o_busy : b1.o_busy) === 1'b1 && busy < 2000) begin
      busy++;
      @(negedge clk);
      if (poke && (busy == 40 || busy == 100)) drive(sel, 1'b1, ~rw, ~a, ~d);
      else drive(sel, 1'b0, rw, a, d);
    end
    #1;
    chk("busy_len", busy, cd * (2 * n + 3));
    chk("done_pulse", (sel == 0) ? b0.o_done : b1.o_done, 1);
    chk("sclk_rises", (sel == 0) ? rise0 : rise1, n);
    chk("mosi_bits", (sel == 0) ? cap0 : cap1, frame_bits(rw, a, d));
    chk("done_count", ((sel == 0) ? done_cnt0 : done_cnt1) - dc0, 1);
    if (rw) begin if (sel == 0) exp_rd0 = sw; else exp_rd1 = sw; end
    chk("rdata", (sel == 0) ? b0.o_rdata : b1.o_rdata, (sel == 0) ? exp_rd0 : exp_rd1);
    if (poke) begin
      repeat (20) @(negedge clk);
      #1;
      chk("poke_no_queue_busy", (sel == 0) ? b0.o_busy : b1.o_busy, 0);
      chk("poke_one_done", ((sel == 0) ? done_cnt0 : done_cnt1) - dc0, 1);
    end
  endtask

  initial begin
    logic [7:0]  a;
    logic [15:0] d, sw;
    int guard, busy, dc0;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sclk0", b0.o_SCLK, 0);  chk("rst_ss0", b0.o_SS, 1);
    chk("rst_mosi0", b0.o_MOSI, 0);  chk("rst_busy0", b0.o_busy, 0);
    chk("rst_done0", b0.o_done, 0);  chk("rst_rdata0", b0.o_rdata, 0);
    chk("rst_sclk1", b1.o_SCLK, 0);  chk("rst_ss1", b1.o_SS, 1);
    chk("rst_busy1", b1.o_busy, 0);  chk("rst_rdata1", b1.o_rdata, 0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Directed write and read.
    run_frame(0, 1'b0, 8'h5A, 16'hBEEF, 16'h0000, 1'b0);
    run_frame(0, 1'b1, 8'h81, 16'hFFFF, 16'h1234, 1'b0);
    // i_start pulses while busy must be ignored.
    run_frame(0, 1'b0, 8'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    // Random mix.
    for (int i = 0; i < 5; i++) begin
      run_frame(0, 1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    end

    // Back-to-back: i_start held high across o_done.
    a = 8'($urandom); d = 16'($urandom);
    @(negedge clk);
    dc0 = done_cnt0;
    drive(0, 1'b1, 1'b0, a, d);
    @(negedge clk);
    guard = 0;
    while (b0.o_busy === 1'b1 && guard < 2000) begin guard++; @(negedge clk); end
    chk("b2b_done1", b0.o_done, 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, a, d);
    chk("b2b_restart", b0.o_busy, 1);
    busy = 0;
    while (b0.o_busy === 1'b1 && busy < 2000) begin busy++; @(negedge clk); end
    #1;
    chk("b2b_busy_len2", busy, 4 * 53);
    chk("b2b_done_count", done_cnt0 - dc0, 2);
    chk("b2b_ss_gap", last_gap0 >= 4, 1);
    chk("b2b_mosi_bits", cap0, frame_bits(1'b0, a, d));

    // Reset in the middle of a write.
    a = 8'($urandom); d = 16'($urandom);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, a, d);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, a, d);
    guard = 0;
    while (rise0 < 11 && guard < 3000) begin guard++; @(negedge clk); end
    chk("rst_mid_reached_bit10", rise0 >= 11, 1);
    dc0 = done_cnt0;
    rst0 = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_ss", b0.o_SS, 1);
    chk("rst_mid_sclk", b0.o_SCLK, 0);
    chk("rst_mid_busy", b0.o_busy, 0);
    chk("rst_mid_done", b0.o_done, 0);
    rst0 = 1'b0;
    exp_rd0 = '0;
    repeat (300) @(negedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt0 - dc0, 0);
    chk("rst_mid_rdata", b0.o_rdata, 0);
    sw = 16'($urandom);
    run_frame(0, 1'b1, 8'($urandom), 16'($urandom), sw, 1'b0);

    // CLK_DIV=2 instance: read then write keeps o_rdata, then random mix.
    run_frame(1, 1'b1, 8'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    run_frame(1, 1'b0, 8'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    end

    repeat (5) @(negedge clk);
    #1;
    chk("ss_edge_sclk_low0", edge_viol0, 0);
    chk("ss_edge_sclk_low1", edge_viol1, 0);
    chk("done_width0", dw_viol0, 0);
    chk("done_width1", dw_viol1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
